// File: rtl/fb_fill_controller.sv
// Framebuffer port-A arbiter: CPU memory-stage accesses pass straight through with priority,
// while a rectangle-fill engine writes one pixel on each cycle the CPU leaves the port free.
module fb_fill_controller #(
   parameter int H_RES        = 320,
   parameter int V_RES        = 240,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cpu_fb_en,
   input  logic        cpu_wen,
   input  logic [16:0] cpu_addr,
   input  logic [11:0] cpu_din,
   output logic        cpu_stall,
   input  logic        fill_start,
   input  logic [8:0]  fill_x0,
   input  logic [7:0]  fill_y0,
   input  logic [8:0]  fill_w,
   input  logic [7:0]  fill_h,
   input  logic [11:0] fill_color,
   output logic        fill_busy,
   output logic        fill_done,
   output logic        fb_wen,
   output logic [16:0] fb_addr,
   output logic [11:0] fb_din
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   localparam int              SW      = $clog2(STARVE_LIMIT + 1);
   localparam logic [9:0]      H_RES_W = 10'(H_RES);
   localparam logic [8:0]      V_RES_W = 9'(V_RES);
   localparam logic [16:0]     H_RES_A = 17'(H_RES);
   localparam logic [SW-1:0]   STARVE_LAST = SW'(STARVE_LIMIT - 1);

   state_t        state, state_next;
   logic [8:0]    x0_q, x_cnt;
   logic [9:0]    x_end;
   logic [7:0]    y_cnt;
   logic [8:0]    y_end;
   logic [16:0]   row_base;
   logic [11:0]   color_q;
   logic [SW-1:0] starve_cnt;
   logic          force_q, force_next;
   logic          fill_done_q;

   logic          grant_fill, row_last, last_px, empty;
   logic [9:0]    x_next, x_sum;
   logic [8:0]    y_next, y_sum;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      grant_fill = (state == FILL) && (!cpu_fb_en || force_q);
      x_next     = {1'b0, x_cnt} + 10'd1;
      y_next     = {1'b0, y_cnt} + 9'd1;
      row_last   = (x_next == x_end);
      last_px    = row_last && (y_next == y_end);
      x_sum      = {1'b0, fill_x0} + {1'b0, fill_w};
      y_sum      = {1'b0, fill_y0} + {1'b0, fill_h};
      empty      = (fill_w == 9'd0) || (fill_h == 8'd0) ||
                   ({1'b0, fill_x0} >= H_RES_W) || ({1'b0, fill_y0} >= V_RES_W);
      force_next = (state == FILL) && cpu_fb_en && !force_q && (starve_cnt == STARVE_LAST);

      state_next = state;
      case (state)
         IDLE:    if (fill_start) state_next = empty ? DONE : FILL;
         FILL:    if (grant_fill && last_px) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      fb_wen    = cpu_wen & cpu_fb_en;
      fb_addr   = cpu_addr;
      fb_din    = cpu_din;
      cpu_stall = cpu_fb_en && force_q && (state == FILL);
      if (grant_fill) begin
         fb_wen  = 1'b1;
         fb_addr = row_base + {8'd0, x_cnt};
         fb_din  = color_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= IDLE;
         starve_cnt  <= '0;
         force_q     <= 1'b0;
         fill_done_q <= 1'b0;
      end else begin
         state       <= state_next;
         force_q     <= force_next;
         fill_done_q <= (state == DONE);
         if (state != FILL || grant_fill)
            starve_cnt <= '0;
         else if (cpu_fb_en && !force_q)
            starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // NOTE: the fill datapath has no reset; it is only observed in FILL and is always loaded on entry.
   always_ff @(posedge clock) begin
      if (state == IDLE && fill_start) begin
         color_q  <= fill_color;
         x0_q     <= fill_x0;
         x_cnt    <= fill_x0;
         y_cnt    <= fill_y0;
         x_end    <= (x_sum > H_RES_W) ? H_RES_W : x_sum;
         y_end    <= (y_sum > V_RES_W) ? V_RES_W : y_sum;
         row_base <= {9'd0, fill_y0} * H_RES_A;
      end else if (grant_fill) begin
         if (row_last) begin
            x_cnt    <= x0_q;
            y_cnt    <= y_cnt + 8'd1;
            row_base <= row_base + H_RES_A;
         end else begin
            x_cnt <= x_next[8:0];
         end
      end
   end

   assign fill_busy = (state != IDLE);
   assign fill_done = fill_done_q;

endmodule
